// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: basic CPU-wide types shared by the datapath blocks.
//   word_t : one 32-bit machine word (addresses, instructions, data).
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pipeline_stage_pkg.sv
// pipeline_stage_pkg: types and constants shared by the elastic pipeline
// stage, its interface and its performance counters.
//   fd_payload_t : fetch/decode payload layout; callers cast in/out data to it.
//   stage_occ_t  : occupancy encoding of the two-entry stage.
//   PERF_CNT_W   : width of the optional performance counters.
package pipeline_stage_pkg;

  import cpu_types_pkg::*;

  localparam int PERF_CNT_W = 32;

  typedef struct packed {
    word_t next_memaddr;
    word_t imemaddr;
    word_t imemload;
  } fd_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_occ_t;

endpackage

// File: rtl/pipeline_stage_elastic_if.sv
// pipeline_stage_elastic_if: one valid/ready/data handshake channel.
//   valid : producer has a beat
//   ready : consumer can take the beat
//   data  : DATA_W-bit payload
// Modports:
//   master : producer side (drives valid/data, samples ready)
//   slave  : consumer side (drives ready, samples valid/data)
interface pipeline_stage_elastic_if #(
  parameter int DATA_W = 96
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipeline_stage_perf_cnt.sv
// pipeline_stage_perf_cnt: saturating event counter.
// Ports:
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   clear : synchronous clear (wins over inc)
//   count : current count, sticks at all-ones
module pipeline_stage_perf_cnt
  import pipeline_stage_pkg::*;
#(
  parameter int WIDTH = PERF_CNT_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stage_elastic.sv
// pipeline_stage_elastic: two-entry (main + skid) elastic pipeline register
// placed between any two pipeline stages.
// Ports:
//   CLK       : clock, rising edge
//   nRST      : asynchronous active-low reset
//   en        : global advance qualifier (ihit); nothing changes while low
//   flush     : drop held and offered beats (only when en is high)
//   up        : upstream channel  (up.valid=in_valid, up.ready=in_ready, up.data=in_data)
//   dn        : downstream channel (dn.valid=out_valid, dn.ready=out_ready, dn.data=out_data)
//   occupancy : entries held, 0..2
//   stall_cnt / flush_cnt : present only when PIPELINE_STAGE_PERF_EN is defined
module pipeline_stage_elastic
  import pipeline_stage_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          en,
  input  logic                          flush,
  pipeline_stage_elastic_if.slave       up,
  pipeline_stage_elastic_if.master      dn,
`ifdef PIPELINE_STAGE_PERF_EN
  output logic [PERF_CNT_W-1:0]         stall_cnt,
  output logic [PERF_CNT_W-1:0]         flush_cnt,
`endif
  output logic [1:0]                    occupancy
);

  stage_occ_t        state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid;
  logic              push;
  logic              pop;

  assign out_valid = (state_q != EMPTY);
  assign push      = up.valid & in_ready_q & en;
  assign pop       = out_valid & dn.ready & en;

  // Next-state: flush wins, otherwise the valid bits walk EMPTY/ONE/FULL.
  // Emptied entries return to RESET_DATA so a drained stage shows a bubble.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (en && flush) begin
      state_d     = EMPTY;
      main_data_d = RESET_DATA;
      skid_data_d = RESET_DATA;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            main_data_d = up.data;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_data_d = up.data;
          end else if (push) begin
            state_d     = FULL;
            skid_data_d = up.data;
          end else if (pop) begin
            state_d     = EMPTY;
            main_data_d = RESET_DATA;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            skid_data_d = RESET_DATA;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_data_d = RESET_DATA;
          skid_data_d = RESET_DATA;
        end
      endcase
    end
    // in_ready is a flop so there is no combinational ready path through us.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_data_q <= RESET_DATA;
      skid_data_q <= RESET_DATA;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign up.ready  = in_ready_q;
  assign dn.valid  = out_valid;
  assign dn.data   = main_data_q;
  assign occupancy = state_q;

`ifdef PIPELINE_STAGE_PERF_EN
  pipeline_stage_perf_cnt #(.WIDTH(PERF_CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (out_valid & ~dn.ready & en),
    .clear (1'b0),
    .count (stall_cnt)
  );

  pipeline_stage_perf_cnt #(.WIDTH(PERF_CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .inc   (flush & en),
    .clear (1'b0),
    .count (flush_cnt)
  );
`endif

endmodule

// File: doc/pipeline_stage_elastic.md
Name: pipeline_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed fetch/decode latch.
- Two-entry skid-buffered pipeline register (main + skid) with a valid/ready handshake on both sides.
- Global advance qualifier `en` (driven from ihit) and a bubble-inserting flush.
- Generic over payload width; instanced between any two pipeline stages (F/D, D/E, E/M, M/W).

Parameters:
- DATA_W, 96: payload width in bits (default = next_memaddr + imemaddr + imemload, 3 x 32).
- RESET_DATA, '0: value loaded into both entries on reset or flush (0 = nop bubble).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- en  input  1  global advance qualifier; no state changes when low.
- flush  input  1  discard all held and incoming beats; qualified by en.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept; registered, equals ~skid_valid.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  main entry valid.
- out_ready  input  1  downstream accepts (0 = stall from hazard unit).
- out_data  output  DATA_W  main entry payload; RESET_DATA when empty.
- occupancy  output  2  entries held: 0, 1 or 2.

Behaviour:
- Reset (nRST low, async): main/skid valid = 0, both data = RESET_DATA, in_ready = 1, out_valid = 0, occupancy = 0.
- Handshake qualifiers:
  - push = in_valid & in_ready & en.
  - pop = out_valid & out_ready & en.
  - in_ready does not depend combinationally on out_ready (no ready path through the stage).
- Latency: 1 cycle from push to out_valid when the stage is empty. Throughput: 1 beat/cycle while out_ready stays high.
- en low: all registers hold, including during flush. This matches the old ihit-gated behaviour.
- flush & en, highest priority:
  - Both entries are invalidated and data is set to RESET_DATA.
  - A beat offered that cycle is dropped.
  - Next cycle: occupancy = 0, in_ready = 1.
- States (encoded by the valid bits): EMPTY, ONE, FULL.
  - EMPTY: push -> ONE, main <= in_data. Otherwise stay.
  - ONE, push & pop: stay ONE, main <= in_data.
  - ONE, push only: -> FULL, skid <= in_data.
  - ONE, pop only: -> EMPTY, main data <= RESET_DATA.
  - FULL (in_ready = 0, push impossible): pop -> ONE, main <= skid, skid <= RESET_DATA. Otherwise stay.
- Ordering: strictly FIFO, so the skid beat always follows the main beat. No beat is duplicated or lost except by flush.
- out_ready low with out_valid high: out_data stays stable until pop.
- Reset asserted mid-transfer: immediate return to EMPTY. In-flight beats are lost.

Optional Feature:
- Macro: PIPELINE_STAGE_PERF_EN.
- When defined, two output ports are added:
  - stall_cnt (32 bits): cycles with out_valid & ~out_ready & en.
  - flush_cnt (32 bits): flush & en cycles.
- Both counters saturate at all-ones and clear on reset.
- When undefined, the ports and counters are absent; datapath behaviour is identical either way.

Decomposition:
- Shared package pipeline_stage_pkg:
  - fd_payload_t: packed struct {word_t next_memaddr; word_t imemaddr; word_t imemload}. Callers cast in_data/out_data to it.
  - stage_occ_t: enum EMPTY=0, ONE=1, FULL=2.
  - PERF_CNT_W = 32.
  - Uses word_t from cpu_types_pkg.
- Sub-module: pipeline_stage_perf_cnt, a saturating counter with inc/clear. Instanced twice under the macro.

Test Plan:
- Reset: assert nRST=0 mid-stream -> out_valid=0, out_data=0, in_ready=1, occupancy=0 asynchronously.
- Streaming: en=1, out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 one cycle later each; occupancy stays 1.
- Backpressure: push 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB, then EMPTY.
- Flush: FULL with 0xA/0xB plus offered 0xC, flush=1, en=1 -> next cycle occupancy=0, out_valid=0, 0xC never appears.
- en gating: en=0 with in_valid=1, out_ready=1, flush=1 for 5 cycles -> no state change. Set en=1 -> normal transfer resumes.
- Perf (macro on): 3 stall cycles, then 2 flushes -> stall_cnt=3, flush_cnt=2. Preload counter to 0xFFFFFFFF -> stays saturated.
